// File: rtl/counter_modn_tap.sv
// counter_modn_tap
//   Parametrised modulo-N step counter for the encoder path. Counts encoder
//   strobes up or down over 0..MODULUS-1, either wrapping or stopping at the
//   terminal value (one-shot). Emits a one-cycle pgt pulse when a step lands
//   on TAP and a one-cycle tc pulse when a step lands on the terminal value.
//
//   Parameters
//     WIDTH    counter width, 2**WIDTH >= MODULUS
//     MODULUS  number of count states, >= 2
//     TAP      count value that fires pgt, < MODULUS
//
//   Ports
//     clk      in   rising-edge clock
//     clear    in   asynchronous active-low reset
//     en       in   step enable, one step per cycle
//     up       in   direction, 1 = up, 0 = down
//     wrap     in   1 = modular wrap, 0 = one-shot
//     restart  in   synchronous reload to start(up), priority over en
//     count    out  current count
//     pgt      out  one-cycle pulse when a step lands on TAP
//     tc       out  one-cycle pulse when a step lands on term(up)
//     done     out  high while the one-shot is finished
module counter_modn_tap #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 7,
  parameter int TAP     = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             up,
  input  logic             wrap,
  input  logic             restart,
  output logic [WIDTH-1:0] count,
  output logic             pgt,
  output logic             tc,
  output logic             done
);

  if ((MODULUS < 2) || (TAP < 0) || (TAP >= MODULUS) ||
      ((longint'(1) << WIDTH) < longint'(MODULUS))) begin : g_bad_params
    $error("counter_modn_tap: illegal WIDTH/MODULUS/TAP combination");
  end

  localparam logic [WIDTH-1:0] MaxV = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] TapV = WIDTH'(TAP);

  typedef enum logic {
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             pgt_q, pgt_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] term_v;
  logic [WIDTH-1:0] start_v;
  logic [WIDTH-1:0] step_v;

  always_comb begin
    term_v  = up ? MaxV : '0;
    start_v = up ? '0 : MaxV;
    step_v  = up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pgt_d   = 1'b0;
    tc_d    = 1'b0;
    done_d  = done_q;

    if (restart) begin
      // Reload never pulses, even when start equals TAP or terminal.
      count_d = start_v;
      state_d = RUN;
      done_d  = 1'b0;
    end else if (en) begin
      unique case (state_q)
        RUN: begin
          if (count_q != term_v) begin
            count_d = step_v;
            pgt_d   = (step_v == TapV);
            if (step_v == term_v) begin
              tc_d = 1'b1;
              if (!wrap) begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end
          end else if (wrap) begin
            // Wrap lands on start(up), which differs from term(up): no tc.
            count_d = start_v;
            pgt_d   = (start_v == TapV);
          end else begin
            // Already at terminal in one-shot mode (e.g. direction changed).
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        DONE: begin
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= RUN;
      count_q <= '0;
      pgt_q   <= 1'b0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pgt_q   <= pgt_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign pgt   = pgt_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: tb/tb_counter_modn_tap.sv
// Scoreboard bench for counter_modn_tap: instance A uses the defaults
// (3/7/4), instance B uses WIDTH=4, MODULUS=10, TAP=0. Both share stimulus.
module tb_counter_modn_tap;

  logic       clk = 1'b0;
  logic       clear, en, up, wrap, restart;
  logic [2:0] count_a;
  logic       pgt_a, tc_a, done_a;
  logic [3:0] count_b;
  logic       pgt_b, tc_b, done_b;

  always #5 clk = ~clk;

  counter_modn_tap dut_a (
    .clk(clk), .clear(clear), .en(en), .up(up), .wrap(wrap), .restart(restart),
    .count(count_a), .pgt(pgt_a), .tc(tc_a), .done(done_a)
  );

  counter_modn_tap #(.WIDTH(4), .MODULUS(10), .TAP(0)) dut_b (
    .clk(clk), .clear(clear), .en(en), .up(up), .wrap(wrap), .restart(restart),
    .count(count_b), .pgt(pgt_b), .tc(tc_b), .done(done_b)
  );

  typedef struct {
    int cnt_a; bit pgt_a; bit tc_a; bit done_a;
    int cnt_b; bit pgt_b; bit tc_b; bit done_b;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model state (plain integers)
  int ma_cnt = 0; bit ma_done = 0;
  int mb_cnt = 0; bit mb_done = 0;

  function automatic void check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // One clock edge of the spec's behaviour, using modular arithmetic.
  task automatic model_step(input int modv, input int tap, inout int cnt,
                            inout bit dn, output bit p, output bit t);
    int term, start;
    p = 1'b0;
    t = 1'b0;
    term  = up ? modv - 1 : 0;
    start = up ? 0 : modv - 1;
    if (!clear) begin
      cnt = 0;
      dn  = 1'b0;
    end else if (restart) begin
      cnt = start;
      dn  = 1'b0;
    end else if (en && !dn) begin
      if (cnt == term && !wrap) begin
        dn = 1'b1;
      end else begin
        cnt = up ? (cnt + 1) % modv : (cnt + modv - 1) % modv;
        p = (cnt == tap);
        t = (cnt == term);
        if (t && !wrap) dn = 1'b1;
      end
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e = '{0, 0, 0, 0, 0, 0, 0, 0};
    return e;
  endfunction

  // Drive inputs for the next rising edge and push the expected outputs.
  task automatic cycle(input bit c, input bit e, input bit u, input bit w, input bit r);
    exp_t x;
    @(negedge clk);
    clear = c; en = e; up = u; wrap = w; restart = r;
    model_step(7, 4, ma_cnt, ma_done, x.pgt_a, x.tc_a);
    model_step(10, 0, mb_cnt, mb_done, x.pgt_b, x.tc_b);
    x.cnt_a = ma_cnt; x.done_a = ma_done;
    x.cnt_b = mb_cnt; x.done_b = mb_done;
    exp_q.push_back(x);
  endtask

  // Monitor: every edge the DUT presents a new output word.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        check("count_a", int'(count_a), x.cnt_a);
        check("pgt_a",   int'(pgt_a),   int'(x.pgt_a));
        check("tc_a",    int'(tc_a),    int'(x.tc_a));
        check("done_a",  int'(done_a),  int'(x.done_a));
        check("count_b", int'(count_b), x.cnt_b);
        check("pgt_b",   int'(pgt_b),   int'(x.pgt_b));
        check("tc_b",    int'(tc_b),    int'(x.tc_b));
        check("done_b",  int'(done_b),  int'(x.done_b));
      end
    end
  end

  initial begin
    clear = 1'b0; en = 1'b0; up = 1'b1; wrap = 1'b1; restart = 1'b0;

    // Reset, then up/wrap for 12 edges (B sees its 9->0 wrap with pgt).
    repeat (2) cycle(0, 0, 1, 1, 0);
    repeat (12) cycle(1, 1, 1, 1, 0);

    // Reset, then one-shot up for 9 edges, then restart.
    cycle(0, 0, 1, 0, 0);
    repeat (9) cycle(1, 1, 1, 0, 0);
    cycle(1, 0, 1, 0, 1);

    // Restart down, then wrap down for 8 edges.
    cycle(1, 0, 0, 1, 1);
    repeat (8) cycle(1, 1, 0, 1, 0);

    // Restart up, step to 3, restart+en together, step to 4, hold 3 cycles.
    cycle(1, 0, 1, 1, 1);
    repeat (3) cycle(1, 1, 1, 1, 0);
    cycle(1, 1, 1, 1, 1);
    repeat (4) cycle(1, 1, 1, 1, 0);
    repeat (3) cycle(1, 0, 1, 1, 0);

    // Step to 5, then drop clear mid-cycle: outputs clear before the edge.
    cycle(1, 1, 1, 1, 0);
    @(negedge clk);
    #2;
    clear = 1'b0;
    #1;
    check("async_count_a", int'(count_a), 0);
    check("async_pgt_a",   int'(pgt_a),   0);
    check("async_tc_a",    int'(tc_a),    0);
    check("async_done_a",  int'(done_a),  0);
    check("async_count_b", int'(count_b), 0);
    ma_cnt = 0; ma_done = 0; mb_cnt = 0; mb_done = 0;
    exp_q.push_back(reset_exp());
    cycle(0, 1, 1, 1, 0);
    repeat (3) cycle(1, 1, 1, 1, 0);

    // Down one-shot from reset: already at terminal, goes DONE without tc.
    cycle(0, 0, 0, 0, 0);
    repeat (2) cycle(1, 1, 0, 0, 0);

    // Randomised phase.
    for (int i = 0; i < 600; i++) begin
      bit c, e, u, w, r;
      c = ($urandom_range(99) != 0);
      e = ($urandom_range(3) != 0);
      r = ($urandom_range(19) == 0);
      u = ($urandom_range(9) == 0) ? ~up : up;
      w = ($urandom_range(9) == 0) ? ~wrap : wrap;
      cycle(c, e, u, w, r);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
